// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter: round-robin share of the L2 L1-side port between D-cache (port 0) and I-cache (port 1); ports: clk/rst, per-port req/we/addr/wdata/be in, ack/err/rdata back, registered l2_rd_en/wr_en/addr/wr_data/byte_en out, l2_hit/fill/rd_data in, grant_o, sticky timeout_err_o
module l2_port_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_i,
  input  logic [1:0]            we_i,
  input  logic [ADDR_WIDTH-1:0] addr0_i,
  input  logic [ADDR_WIDTH-1:0] addr1_i,
  input  logic [DATA_WIDTH-1:0] wdata0_i,
  input  logic [DATA_WIDTH-1:0] wdata1_i,
  input  logic [3:0]            be0_i,
  input  logic [3:0]            be1_i,
  output logic [1:0]            ack_o,
  output logic                  err_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  l2_rd_en_o,
  output logic                  l2_wr_en_o,
  output logic [ADDR_WIDTH-1:0] l2_addr_o,
  output logic [DATA_WIDTH-1:0] l2_wr_data_o,
  output logic [3:0]            l2_byte_en_o,
  input  logic                  l2_hit_i,
  input  logic                  l2_fill_i,
  input  logic [DATA_WIDTH-1:0] l2_rd_data_i,
  output logic                  grant_o,
  output logic                  timeout_err_o
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(TIMEOUT_CYCLES == 0 ? 0 : TIMEOUT_CYCLES - 1);
  state_t state, state_nx;
  logic [CNT_WIDTH-1:0] cnt;
  logic err_q, win, done, expire;
  assign win    = &req_i ? ~grant_o : req_i[1];
  assign done   = l2_hit_i | l2_fill_i;
  assign expire = TIMEOUT_CYCLES != 0 && cnt == CNT_MAX;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (|req_i ? BUSY : IDLE) :
               state == BUSY ? (done | expire ? RESP : BUSY) : IDLE;
  always_comb begin
    ack_o = state == RESP ? (grant_o ? 2'b10 : 2'b01) : 2'b00;
    err_o = state == RESP && err_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rdata_o       <= '0;
      l2_rd_en_o    <= 1'b0;
      l2_wr_en_o    <= 1'b0;
      l2_addr_o     <= '0;
      l2_wr_data_o  <= '0;
      l2_byte_en_o  <= '0;
      grant_o       <= 1'b1;
      timeout_err_o <= 1'b0;
      cnt           <= '0;
      err_q         <= 1'b0;
    end else if (state == IDLE && |req_i) begin
      l2_addr_o    <= win ? addr1_i : addr0_i;
      l2_wr_data_o <= win ? wdata1_i : wdata0_i;
      l2_byte_en_o <= win ? be1_i : be0_i;
      l2_wr_en_o   <= we_i[win];
      l2_rd_en_o   <= ~we_i[win];
      grant_o      <= win;
      cnt          <= '0;
    end else if (state == BUSY) begin
      if (done | expire) begin
        l2_rd_en_o <= 1'b0;
        l2_wr_en_o <= 1'b0;
        rdata_o    <= done && !l2_wr_en_o ? l2_rd_data_i : '0;
        err_q      <= ~done;
      end else cnt <= cnt + 1'b1;
      if (!done && expire) timeout_err_o <= 1'b1;
    end
endmodule

// File: tb/tb_l2_port_arbiter.sv
// tb_l2_port_arbiter: randomized transaction-level check of l2_port_arbiter against a round-robin reference model
module tb_l2_port_arbiter;
  localparam int TO = 8;
  logic clk = 0, rst = 1;
  logic [1:0] req_i = 0, we_i = 0;
  logic [31:0] addr0_i = 0, addr1_i = 0, wdata0_i = 0, wdata1_i = 0, l2_rd_data_i = 0;
  logic [3:0] be0_i = 0, be1_i = 0;
  logic l2_hit_i = 0, l2_fill_i = 0;
  logic [1:0] ack_o;
  logic err_o, l2_rd_en_o, l2_wr_en_o, grant_o, timeout_err_o;
  logic [31:0] rdata_o, l2_addr_o, l2_wr_data_o;
  logic [3:0] l2_byte_en_o;
  always #5 clk = ~clk;
  l2_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .addr0_i(addr0_i), .addr1_i(addr1_i),
    .wdata0_i(wdata0_i), .wdata1_i(wdata1_i), .be0_i(be0_i), .be1_i(be1_i), .ack_o(ack_o),
    .err_o(err_o), .rdata_o(rdata_o), .l2_rd_en_o(l2_rd_en_o), .l2_wr_en_o(l2_wr_en_o),
    .l2_addr_o(l2_addr_o), .l2_wr_data_o(l2_wr_data_o), .l2_byte_en_o(l2_byte_en_o),
    .l2_hit_i(l2_hit_i), .l2_fill_i(l2_fill_i), .l2_rd_data_i(l2_rd_data_i),
    .grant_o(grant_o), .timeout_err_o(timeout_err_o));
  int checks = 0, errors = 0;
  bit pend [2];
  bit we_m [2];
  logic [31:0] addr_m [2], wd_m [2];
  logic [3:0] be_m [2];
  int last = 1, rereq = 2;
  bit sticky = 0;
  logic [31:0] rd_exp = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic new_req(input int p, input bit we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    pend[p] = 1; we_m[p] = we; addr_m[p] = a; wd_m[p] = d; be_m[p] = b;
  endtask
  task automatic rand_req(input int p);
    new_req(p, 1'($urandom), $urandom, $urandom, 4'($urandom));
  endtask
  task automatic drive_ports();
    req_i = {pend[1], pend[0]};
    we_i = {we_m[1], we_m[0]};
    addr0_i = addr_m[0]; addr1_i = addr_m[1];
    wdata0_i = wd_m[0]; wdata1_i = wd_m[1];
    be0_i = be_m[0]; be1_i = be_m[1];
  endtask
  task automatic check_req(input string tag, input int w);
    chk({tag, "_rd_en"}, l2_rd_en_o, !we_m[w]);
    chk({tag, "_wr_en"}, l2_wr_en_o, we_m[w]);
    chk({tag, "_addr"}, l2_addr_o, addr_m[w]);
    chk({tag, "_wdata"}, l2_wr_data_o, wd_m[w]);
    chk({tag, "_be"}, l2_byte_en_o, be_m[w]);
    chk({tag, "_ack"}, ack_o, 0);
  endtask
  task automatic idle_cycle();
    req_i = 0;
    l2_hit_i = 1;
    l2_fill_i = 1'($urandom);
    tick();
    l2_hit_i = 0;
    l2_fill_i = 0;
    chk("stray_ack", ack_o, 0);
    chk("stray_en", {l2_rd_en_o, l2_wr_en_o}, 0);
    chk("stray_grant", grant_o, last);
  endtask
  // d = BUSY cycle index of completion (>= TO means never), mode 0 hit, 1 fill, 2 both
  task automatic txn(input int d, input int mode, input logic [31:0] rdv);
    int w;
    bit to;
    logic [31:0] rd;
    w = (pend[0] && pend[1]) ? 1 - last : (pend[1] ? 1 : 0);
    drive_ports();
    tick();
    last = w;
    chk("grant", grant_o, w);
    check_req("start", w);
    we_i[w] = ~we_m[w];
    if (w == 0) begin addr0_i = $urandom; wdata0_i = $urandom; be0_i = 4'($urandom); end
    else begin addr1_i = $urandom; wdata1_i = $urandom; be1_i = 4'($urandom); end
    to = d >= TO;
    rd = 0;
    for (int k = 0; k <= (to ? TO - 1 : d); k++) begin
      rd = (rdv != 0 && k == d) ? rdv : $urandom;
      l2_rd_data_i = rd;
      l2_hit_i = k == d && mode != 1;
      l2_fill_i = k == d && mode != 0;
      if (k > 0) check_req("hold", w);
      tick();
    end
    l2_hit_i = 1'($urandom);
    l2_fill_i = 1'($urandom);
    sticky |= to;
    rd_exp = (to || we_m[w]) ? 32'h0 : rd;
    chk("ack", ack_o, w ? 2'b10 : 2'b01);
    chk("err", err_o, to);
    chk("rdata", rdata_o, rd_exp);
    chk("en_drop", {l2_rd_en_o, l2_wr_en_o}, 0);
    chk("sticky", timeout_err_o, sticky);
    pend[w] = 0;
    if (rereq == 1 || (rereq == 2 && $urandom_range(0, 2) == 0)) rand_req(w);
    if (rereq == 2 && !pend[1 - w] && $urandom_range(0, 1) == 0) rand_req(1 - w);
    drive_ports();
    tick();
    l2_hit_i = 0;
    l2_fill_i = 0;
    chk("ack_clr", ack_o, 0);
    chk("err_clr", err_o, 0);
    chk("rdata_hold", rdata_o, rd_exp);
  endtask
  initial begin
    pend[0] = 0; pend[1] = 0;
    for (int p = 0; p < 2; p++) begin we_m[p] = 0; addr_m[p] = 0; wd_m[p] = 0; be_m[p] = 0; end
    tick();
    chk("rst_ack", ack_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_en", {l2_rd_en_o, l2_wr_en_o}, 0);
    chk("rst_addr", l2_addr_o, 0);
    chk("rst_wdata", l2_wr_data_o, 0);
    chk("rst_be", l2_byte_en_o, 0);
    chk("rst_grant", grant_o, 1);
    chk("rst_tmo", timeout_err_o, 0);
    rst = 0;
    tick();
    new_req(0, 0, 32'h100, 32'h0, 4'hf);
    rereq = 0;
    txn(0, 0, 32'hDEADBEEF);
    idle_cycle();
    rereq = 1;
    rand_req(0);
    rand_req(1);
    for (int i = 0; i < 4; i++) txn($urandom_range(0, 3), $urandom_range(0, 2), 0);
    rereq = 0;
    for (int i = 0; i < 2 && (pend[0] || pend[1]); i++) txn(0, 0, 0);
    new_req(1, 1, 32'h2000, 32'h1234ABCD, 4'b0011);
    txn(6, 1, 0);
    rand_req(0);
    we_m[0] = 0;
    txn(20, 0, 0);
    rereq = 2;
    for (int i = 0; i < 150; i++) begin
      if (!pend[0] && $urandom_range(0, 2) == 0) rand_req(0);
      if (!pend[1] && $urandom_range(0, 2) == 0) rand_req(1);
      if (pend[0] || pend[1]) txn($urandom_range(0, 10), $urandom_range(0, 2), 0);
      else idle_cycle();
    end
    rereq = 0;
    for (int i = 0; i < 2 && (pend[0] || pend[1]); i++) txn(0, 0, 0);
    rand_req(1);
    we_m[1] = 0;
    drive_ports();
    tick();
    chk("pre_rst_grant", grant_o, 1);
    chk("pre_rst_rd_en", l2_rd_en_o, 1);
    tick();
    #2 rst = 1;
    #1;
    chk("midrst_rd_en", l2_rd_en_o, 0);
    chk("midrst_ack", ack_o, 0);
    chk("midrst_tmo", timeout_err_o, 0);
    chk("midrst_grant", grant_o, 1);
    pend[1] = 0;
    drive_ports();
    tick();
    chk("inrst_ack", ack_o, 0);
    rst = 0;
    sticky = 0;
    last = 1;
    tick();
    rand_req(0);
    rand_req(1);
    txn(1, 0, 0);
    chk("post_rst_winner", last, 0);
    txn(0, 2, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/l2_port_arbiter.md
Name: l2_port_arbiter

Overview:
- Two-requester arbiter sharing the single L1-side port of the unified L2 cache between L1 D-cache (port 0) and L1 I-cache (port 1).
- Round-robin grant; a grant is held until the L2 completes the access, either as a hit or as a fill from L3.
- All L2-facing request signals are registered and held stable for the whole transaction.
- A watchdog terminates transactions that never complete.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; fixed 4 byte lanes.
- TIMEOUT_CYCLES, 1024, max BUSY cycles before forced completion; 0 disables the watchdog.
- CNT_WIDTH, 11, watchdog counter width; must satisfy 2^CNT_WIDTH > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_i  in  2  per-port request, held high until that port's ack
- we_i  in  2  per-port write (1) / read (0)
- addr0_i, addr1_i  in  ADDR_WIDTH  per-port address
- wdata0_i, wdata1_i  in  DATA_WIDTH  per-port write data
- be0_i, be1_i  in  4  per-port byte enables
- ack_o  out  2  one-cycle completion pulse per port
- err_o  out  1  completion was a timeout; valid with ack_o
- rdata_o  out  DATA_WIDTH  read data, valid with ack_o
- l2_rd_en_o  out  1  L2 read enable
- l2_wr_en_o  out  1  L2 write enable
- l2_addr_o  out  ADDR_WIDTH  L2 address
- l2_wr_data_o  out  DATA_WIDTH  L2 write data
- l2_byte_en_o  out  4  L2 byte enables
- l2_hit_i  in  1  L2 hit, combinational from the current L2 request
- l2_fill_i  in  1  L3 data valid; miss fill completing this cycle
- l2_rd_data_i  in  DATA_WIDTH  L2 read data
- grant_o  out  1  currently/last granted port index
- timeout_err_o  out  1  sticky watchdog flag

Behaviour:
- Reset (async), all of the following cleared:
  - state=IDLE; ack_o=0, err_o=0, rdata_o=0.
  - l2_rd_en_o=0, l2_wr_en_o=0; l2_addr_o, l2_wr_data_o and l2_byte_en_o = 0.
  - last_grant=1, so port 0 wins the first contention; grant_o=1.
  - timeout_err_o=0; watchdog counter=0.
- Reset mid-transaction aborts it: no ack is issued and L2 enables drop immediately.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If any req_i bit is set, select the winner: single requester wins; both requesting gives the port != last_grant.
  - On the clock edge, latch the winner's addr/wdata/be into the l2_* regs, set l2_wr_en_o=we or l2_rd_en_o=!we, set grant_o=winner and last_grant=winner, clear the counter, go to BUSY.
- BUSY:
  - l2_* outputs held constant.
  - done = l2_hit_i | l2_fill_i.
  - On done:
    - capture l2_rd_data_i into rdata_o (0 for writes);
    - drop the L2 enables;
    - set ack_o[grant]=1, err_o=0;
    - go to RESP.
  - Else if TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1:
    - drop the L2 enables; set ack_o[grant]=1, err_o=1, rdata_o=0;
    - set timeout_err_o=1 (sticky);
    - go to RESP.
  - Else increment the counter.
- RESP:
  - ack_o and err_o high for exactly this one cycle.
  - Requests are not sampled.
  - Next edge: clear ack_o/err_o, go to IDLE. rdata_o holds its value until the next capture.
- Requester protocol:
  - Deassert req the cycle after ack.
  - A requester that keeps req high is re-arbitrated in IDLE; round-robin still alternates when both request.
- Latency: req seen in IDLE cycle N, L2 enable in N+1, L2 hit in N+1, ack in N+2. Miss with fill at cycle F gives ack at F+1.
- Minimum back-to-back spacing per transaction is 3 cycles (IDLE, BUSY, RESP).
- l2_hit_i and l2_fill_i are ignored outside BUSY. If both are asserted the same cycle, this is a single completion and data comes from l2_rd_data_i.
- we_i, addr, wdata and be are sampled only at grant; later changes have no effect.
- req_i must be deasserted at rst release.

Test Plan:
- Single read hit: port0 req, addr=0x100, l2_hit_i=1 in BUSY, l2_rd_data_i=0xDEADBEEF -> l2_rd_en_o high 1 cycle at N+1; ack_o=2'b01 and rdata_o=0xDEADBEEF at N+2; err_o=0.
- Contention: both ports request at reset release, each re-asserts after its ack -> grants alternate 0,1,0,1 over four transactions; l2_addr_o matches the granted port's address each time.
- Miss with fill: port1 write, addr=0x2000, be=4'b0011, wdata=0x1234ABCD; no hit; l2_fill_i pulses after 6 BUSY cycles -> l2_wr_en_o, l2_addr_o, l2_byte_en_o stable all 6 cycles; ack_o=2'b10 on the following cycle.
- Timeout: TIMEOUT_CYCLES=8, no hit/fill -> ack_o pulse after 8 BUSY cycles with err_o=1, rdata_o=0; timeout_err_o stays 1 through subsequent normal transactions.
- Reset mid-BUSY: assert rst during a pending miss -> l2_rd_en_o=0 and ack_o=0 immediately; after release, port 0 wins the first contention.
- Stray completion: l2_hit_i=1 while in IDLE with no req -> no ack, no state change.
